// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR word generator.
//   - Default Fibonacci tap masks for common widths.
//   - Word packer state enum.
//   - Zero-seed substitution helper (the all-zero state is a lock-up state).
package lfsr_pkg;

  localparam logic [3:0]  TapsW4  = 4'hC;
  localparam logic [7:0]  TapsW8  = 8'hB8;
  localparam logic [12:0] TapsW13 = 13'h100D;
  localparam logic [15:0] TapsW16 = 16'hB400;
  localparam logic [31:0] TapsW32 = 32'h8020_0003;

  typedef enum logic {StFill, StFull} word_st_e;

  // Callers zero-extend the seed to 64 bits and size-cast the result back.
  function automatic logic [63:0] fix_seed(input logic [63:0] s);
    return (s == 64'd0) ? 64'd1 : s;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: W-bit LFSR state register and single-step logic.
// Form selected by macro LFSR_GALOIS_EN (defined: Galois, undefined: Fibonacci).
// Ports:
//   clk        clock
//   i_rst      synchronous active-high reset, loads SEED_RST
//   i_load     load i_load_val (lower priority than i_rst)
//   i_load_val new state (caller guarantees nonzero)
//   i_step     advance one step (lowest priority)
//   o_state    current state
//   o_next     state after one step
//   o_bit      bit packed into the output word for this step
module lfsr_core #(
  parameter int unsigned     W        = 13,
  parameter logic [W-1:0]    TAPS     = 13'h100D,
  parameter logic [W-1:0]    SEED_RST = 1
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_step,
  output logic [W-1:0] o_state,
  output logic [W-1:0] o_next,
  output logic         o_bit
);

`ifdef LFSR_GALOIS_EN
  localparam logic [W-1:0] TapsGal = {TAPS[W-2:0], 1'b1};
`endif

  logic [W-1:0] r_state;

  always_comb begin
`ifdef LFSR_GALOIS_EN
    o_bit  = r_state[W-1];
    o_next = r_state[W-1] ? ({r_state[W-2:0], 1'b0} ^ TapsGal) : {r_state[W-2:0], 1'b0};
`else
    o_bit  = ^(r_state & TAPS);
    o_next = {r_state[W-2:0], o_bit};
`endif
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state <= SEED_RST;
    end else if (i_load) begin
      r_state <= i_load_val;
    end else if (i_step) begin
      r_state <= o_next;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/lfsr_word_gen.sv
// lfsr_word_gen: LFSR pseudo-random word generator with valid/ready output.
// Successive step bits are packed MSB-first into OW-bit words; the LFSR stalls
// while a full word is held under backpressure. lfsr_done pulses when the state
// returns to the value it was started from (reset or seed_load).
// Macro LFSR_GALOIS_EN selects the Galois step form (see lfsr_core).
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   seed_load   load seed (zero replaced by 1), aborts any word in progress
//   seed        new start state
//   ce          step enable
//   word_valid  word holds a complete word
//   word_ready  consumer accepts word
//   word        packed bits, first bit in the MSB
//   lfsr        current LFSR state
//   lfsr_done   one-cycle pulse when lfsr equals the start value again
module lfsr_word_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned  W            = 13,
  parameter logic [W-1:0] TAPS         = 13'h100D,
  parameter int unsigned  OW           = 8,
  parameter logic [W-1:0] SEED_DEFAULT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          seed_load,
  input  logic [W-1:0]  seed,
  input  logic          ce,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [OW-1:0] word,
  output logic [W-1:0]  lfsr,
  output logic          lfsr_done
);

  localparam int unsigned   CW      = $clog2(OW) + 1;
  localparam logic [W-1:0]  SeedRst = W'(fix_seed(64'(SEED_DEFAULT)));

  word_st_e      r_st, w_st_d;
  logic [CW-1:0] r_cnt, w_cnt_d;
  logic [OW-1:0] r_wsr;
  logic [W-1:0]  r_start;
  logic [W-1:0]  r_step_cnt;
  logic          r_done;

  logic          w_step;
  logic          w_bit;
  logic          w_hit;
  logic [W-1:0]  w_next;
  logic [W-1:0]  w_seed_fix;
  logic [W-1:0]  w_cnt_inc;

  assign w_seed_fix = W'(fix_seed(64'(seed)));

  // A held full word freezes the LFSR; the transfer cycle may step.
  assign w_step    = ce & ((r_st == StFill) | word_ready);
  assign w_cnt_inc = r_step_cnt + W'(1);
  // Steps since load or last pulse; a wrapped counter never reports a match.
  assign w_hit     = w_step && (w_next == r_start) && (w_cnt_inc != '0);

  lfsr_core #(
    .W        (W),
    .TAPS     (TAPS),
    .SEED_RST (SeedRst)
  ) u_core (
    .clk        (clk),
    .i_rst      (rst),
    .i_load     (seed_load),
    .i_load_val (w_seed_fix),
    .i_step     (w_step),
    .o_state    (lfsr),
    .o_next     (w_next),
    .o_bit      (w_bit)
  );

  always_comb begin
    w_st_d  = r_st;
    w_cnt_d = r_cnt;
    unique case (r_st)
      StFill: begin
        if (w_step) begin
          if (r_cnt == CW'(OW - 1)) begin
            w_st_d  = StFull;
            w_cnt_d = '0;
          end else begin
            w_cnt_d = r_cnt + CW'(1);
          end
        end
      end
      StFull: begin
        if (word_ready) begin
          w_st_d  = StFill;
          // A step in the transfer cycle is the first bit of the next word.
          w_cnt_d = ce ? CW'(1) : '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st       <= StFill;
      r_cnt      <= '0;
      r_wsr      <= '0;
      r_start    <= SeedRst;
      r_step_cnt <= '0;
      r_done     <= 1'b0;
    end else if (seed_load) begin
      r_st       <= StFill;
      r_cnt      <= '0;
      r_wsr      <= '0;
      r_start    <= w_seed_fix;
      r_step_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_st   <= w_st_d;
      r_cnt  <= w_cnt_d;
      r_done <= w_hit;
      if (w_step) begin
        r_wsr      <= {r_wsr[OW-2:0], w_bit};
        r_step_cnt <= w_hit ? '0 : w_cnt_inc;
      end
    end
  end

  assign word_valid = (r_st == StFull);
  assign word       = r_wsr;
  assign lfsr_done  = r_done;

endmodule

// File: tb/tb_lfsr_word_gen.sv
module tb_lfsr_word_gen;

  localparam int unsigned W    = 4;
  localparam logic [3:0]  TAPS = 4'b1100;
  localparam int unsigned OW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small-config DUT
  logic          rst = 1'b1, seed_load = 1'b0, ce = 1'b0, word_ready = 1'b0;
  logic [W-1:0]  seed = '0;
  logic          word_valid, lfsr_done;
  logic [OW-1:0] word;
  logic [W-1:0]  lfsr;

  lfsr_word_gen #(
    .W            (W),
    .TAPS         (TAPS),
    .OW           (OW),
    .SEED_DEFAULT (4'd1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .seed       (seed),
    .ce         (ce),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word       (word),
    .lfsr       (lfsr),
    .lfsr_done  (lfsr_done)
  );

  // Default-config DUT for the full-period check
  logic        rst13 = 1'b1;
  logic        seed_load13 = 1'b0;
  logic [12:0] seed13 = '0;
  logic        word_valid13, lfsr_done13;
  logic [7:0]  word13;
  logic [12:0] lfsr13;

  lfsr_word_gen dut13 (
    .clk        (clk),
    .rst        (rst13),
    .seed_load  (seed_load13),
    .seed       (seed13),
    .ce         (1'b1),
    .word_valid (word_valid13),
    .word_ready (1'b1),
    .word       (word13),
    .lfsr       (lfsr13),
    .lfsr_done  (lfsr_done13)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0]  m_lfsr, m_start;
  logic [OW-1:0] m_word;
  int            m_nbits;   // bits collected in current word; OW means word held
  logic          m_done;
  bit            chk_en = 1'b0;

  function automatic logic [W:0] model_step(input logic [W-1:0] s);
    logic         fb;
    logic [W-1:0] nx;
`ifdef LFSR_GALOIS_EN
    fb = s[W-1];
    nx = W'(s << 1);
    if (fb) nx = nx ^ W'((TAPS << 1) | 4'd1);
`else
    fb = ($countones(s & TAPS) % 2) == 1;
    nx = W'((s * 2 + fb) % (1 << W));
`endif
    return {fb, nx};
  endfunction

  task automatic model_advance();
    logic [W:0] r;
    bit         do_step;
    if (rst) begin
      m_lfsr = 1; m_start = 1; m_word = '0; m_nbits = 0; m_done = 1'b0;
    end else if (seed_load) begin
      m_lfsr  = (seed == 0) ? W'(1) : seed;
      m_start = m_lfsr; m_word = '0; m_nbits = 0; m_done = 1'b0;
    end else begin
      do_step = ce && ((m_nbits < OW) || word_ready);
      if ((m_nbits == OW) && word_ready) m_nbits = 0;
      m_done = 1'b0;
      if (do_step) begin
        r       = model_step(m_lfsr);
        m_lfsr  = r[W-1:0];
        m_word  = OW'((m_word * 2 + r[W]) % (1 << OW));
        m_nbits = m_nbits + 1;
        m_done  = (m_lfsr == m_start);
      end
    end
  endtask

  always @(posedge clk) model_advance();

  // Single compare process against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("lfsr", 64'(lfsr), 64'(m_lfsr));
      check("word_valid", 64'(word_valid), 64'(m_nbits == OW));
      check("lfsr_done", 64'(lfsr_done), 64'(m_done));
      if (m_nbits == OW) check("word", 64'(word), 64'(m_word));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; seed_load = 1'b0; ce = 1'b0; word_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] exp_seq [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                               4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
  int pulses[$];
  bit zero13;

  initial begin
    tick();
    tick();
    chk_en = 1'b1;
    // Reset state
    check("rst_lfsr", 64'(lfsr), 64'd1);
    check("rst_word", 64'(word), 64'd0);
    check("rst_valid", 64'(word_valid), 64'd0);
    check("rst_done", 64'(lfsr_done), 64'd0);
    check("rst13_lfsr", 64'(lfsr13), 64'd1);

    // Free-running sequence and words
    rst = 1'b0; ce = 1'b1; word_ready = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
`ifndef LFSR_GALOIS_EN
      check("seq_lfsr", 64'(lfsr), 64'(exp_seq[k-1]));
      if (k == 4)  check("seq_word0", 64'(word), 64'h3);
      if (k == 8)  check("seq_word1", 64'(word), 64'h5);
      if (k == 12) check("seq_word2", 64'(word), 64'hE);
`endif
      if (k == 4 || k == 8 || k == 12) check("seq_valid", 64'(word_valid), 64'd1);
      if (k == 5) check("seq_valid_drop", 64'(word_valid), 64'd0);
      check("seq_done", 64'(lfsr_done), 64'(k == 15));
    end

    // Backpressure: first word held for 10 cycles
    do_reset();
    ce = 1'b1; word_ready = 1'b1;
    repeat (4) tick();
    word_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_valid", 64'(word_valid), 64'd1);
`ifndef LFSR_GALOIS_EN
      check("bp_word", 64'(word), 64'h3);
      check("bp_lfsr", 64'(lfsr), 64'h3);
`endif
    end
    word_ready = 1'b1;
    tick();
    check("bp_xfer", 64'(word_valid), 64'd0);
    repeat (3) tick();
    check("bp_valid2", 64'(word_valid), 64'd1);
`ifndef LFSR_GALOIS_EN
    check("bp_word2", 64'(word), 64'h5);
`endif

    // seed_load with zero seed
    seed_load = 1'b1; seed = '0;
    tick();
    seed_load = 1'b0;
    check("z_lfsr", 64'(lfsr), 64'd1);
    check("z_valid", 64'(word_valid), 64'd0);
    check("z_word", 64'(word), 64'd0);
    repeat (4) tick();
    check("z_valid2", 64'(word_valid), 64'd1);
`ifndef LFSR_GALOIS_EN
    check("z_word2", 64'(word), 64'h3);
`endif

    // seed_load 0xA mid-word
    do_reset();
    ce = 1'b1; word_ready = 1'b1;
    repeat (2) tick();
    seed_load = 1'b1; seed = 4'hA;
    tick();
    seed_load = 1'b0;
    check("a_lfsr", 64'(lfsr), 64'hA);
    check("a_valid", 64'(word_valid), 64'd0);
    repeat (14) tick();
    check("a_done14", 64'(lfsr_done), 64'd0);
    tick();
    check("a_done15", 64'(lfsr_done), 64'd1);
    check("a_lfsr15", 64'(lfsr), 64'hA);

    // ce gap mid-fill
    do_reset();
    ce = 1'b1; word_ready = 1'b1;
    repeat (2) tick();
    ce = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
`ifndef LFSR_GALOIS_EN
      check("gap_lfsr", 64'(lfsr), 64'h4);
`endif
      check("gap_valid", 64'(word_valid), 64'd0);
    end
    ce = 1'b1;
    tick();
    check("gap_valid_early", 64'(word_valid), 64'd0);
    tick();
    check("gap_valid", 64'(word_valid), 64'd1);
`ifndef LFSR_GALOIS_EN
    check("gap_word", 64'(word), 64'h3);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      seed_load  = ($urandom_range(0, 39) == 0);
      seed       = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom);
      ce         = ($urandom_range(0, 3) != 0);
      word_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b0; seed_load = 1'b0;

    // Full period of the default 13-bit configuration
    rst13  = 1'b0;
    zero13 = 1'b0;
    for (int k = 1; k <= 16390; k++) begin
      tick();
      if (lfsr13 == '0) zero13 = 1'b1;
      if (lfsr_done13) begin
        pulses.push_back(k);
        check("p13_lfsr_at_done", 64'(lfsr13), 64'd1);
      end
    end
    check("p13_pulses", 64'(pulses.size()), 64'd2);
    check("p13_no_zero", 64'(zero13), 64'd0);
    if (pulses.size() >= 1) check("p13_first", 64'(pulses[0]), 64'd8191);
    else check("p13_first_missing", 64'd0, 64'd8191);
    if (pulses.size() >= 2) check("p13_period", 64'(pulses[1] - pulses[0]), 64'd8191);
    else check("p13_period_missing", 64'd0, 64'd8191);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
